rob_16: RTL and testbench

- 16-entry in-order reorder buffer for the Tomasulo MIPS pipeline. Sits directly upstream of the reservation station.
- Allocates a 4-bit rob tag per dispatched instruction; the RS receives it as its `dest` input.
- Answers two operand tag lookups, which are the RS `rd_rb_tag1/2` and `rd_bsy1/2` inputs.
- Captures results broadcast on the CDB and retires entries in program order to the register file.

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_16_read_port.sv | 30 +++
 rtl/rob_16.sv | 107 ++++++++++
 tb/tb_rob_16.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and constants.
// The reservation station imports rob_tag_t from here for its dest and rd_rb_tag ports.
package rob_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_TAG_W = 4;
   localparam int unsigned XLEN      = 32;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic            bsy;
      logic            rdy;
      logic [4:0]      dest_reg;
      logic [XLEN-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/rob_16_read_port.sv
// One operand tag lookup into the reorder buffer.
// A matching CDB broadcast in the same cycle overrides the stored entry.
module rob_read_port #(
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic [TAG_W-1:0]  rd_tag,
   input  logic              entry_bsy,
   input  logic              entry_rdy,
   input  logic [DATA_W-1:0] entry_value,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              rd_bsy,
   output logic [DATA_W-1:0] rd_val
);

   always_comb begin
      rd_bsy = 1'b1;
      rd_val = '0;
      if (cdb_valid && (cdb_tag == rd_tag) && entry_bsy) begin
         rd_bsy = 1'b0;
         rd_val = cdb_data;
      end else if (entry_bsy && entry_rdy) begin
         rd_bsy = 1'b0;
         rd_val = entry_value;
      end
   end

endmodule

// File: rtl/rob_16.sv
// 16-entry in-order reorder buffer: allocates tags at dispatch, captures CDB
// results, answers two operand lookups and retires one entry per cycle in order.
module rob_16
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH  = ROB_DEPTH,
   parameter int unsigned TAG_W  = ROB_TAG_W,
   parameter int unsigned DATA_W = XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [4:0]        alloc_dest_reg,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [TAG_W-1:0]  rd_tag1,
   input  logic [TAG_W-1:0]  rd_tag2,
   output logic              rd_bsy1,
   output logic              rd_bsy2,
   output logic [DATA_W-1:0] rd_val1,
   output logic [DATA_W-1:0] rd_val2,
   output logic              commit_valid,
   output logic [4:0]        commit_reg,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   input  logic              flush,
   output logic [TAG_W:0]    count
);

   rob_entry_t       entries [DEPTH];
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic             alloc_fire;
   logic             commit_fire;

   // Full/empty come from count, so head == tail is ambiguous on purpose.
   assign alloc_ready  = (count != (TAG_W+1)'(DEPTH));
   assign alloc_tag    = tail;
   assign alloc_fire   = alloc_valid && alloc_ready;

   assign commit_valid = entries[head].bsy && entries[head].rdy;
   assign commit_fire  = commit_valid;
   assign commit_reg   = entries[head].dest_reg;
   assign commit_data  = entries[head].value;
   assign commit_tag   = head;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (cdb_valid && entries[cdb_tag].bsy) begin
            entries[cdb_tag].rdy   <= 1'b1;
            entries[cdb_tag].value <= cdb_data;
         end
         // Commit is ordered after capture so a retiring head always clears.
         if (commit_fire) begin
            entries[head].bsy <= 1'b0;
            entries[head].rdy <= 1'b0;
            head              <= head + TAG_W'(1);
         end
         if (alloc_fire) begin
            entries[tail].bsy      <= 1'b1;
            entries[tail].rdy      <= 1'b0;
            entries[tail].dest_reg <= alloc_dest_reg;
            tail                   <= tail + TAG_W'(1);
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   rob_read_port #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_port1 (
      .rd_tag      (rd_tag1),
      .entry_bsy   (entries[rd_tag1].bsy),
      .entry_rdy   (entries[rd_tag1].rdy),
      .entry_value (entries[rd_tag1].value),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .rd_bsy      (rd_bsy1),
      .rd_val      (rd_val1)
   );

   rob_read_port #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_port2 (
      .rd_tag      (rd_tag2),
      .entry_bsy   (entries[rd_tag2].bsy),
      .entry_rdy   (entries[rd_tag2].rdy),
      .entry_value (entries[rd_tag2].value),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .rd_bsy      (rd_bsy2),
      .rd_val      (rd_val2)
   );

endmodule

// File: tb/tb_rob_16.sv
// Randomized and directed bench for rob_16 against an in-order queue model.
module tb_rob_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [4:0]  alloc_dest_reg;
   logic        alloc_ready;
   logic [3:0]  alloc_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [3:0]  rd_tag1, rd_tag2;
   logic        rd_bsy1, rd_bsy2;
   logic [31:0] rd_val1, rd_val2;
   logic        commit_valid;
   logic [4:0]  commit_reg;
   logic [31:0] commit_data;
   logic [3:0]  commit_tag;
   logic        flush;
   logic [4:0]  count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      bit          rdy;
      logic [31:0] val;
   } ent_t;

   // Instructions in flight, oldest first; tags are issued sequentially mod 16.
   ent_t        q[$];
   int unsigned m_tail = 0;

   always #5 clk = ~clk;

   rob_16 #(.DEPTH(16), .TAG_W(4), .DATA_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_dest_reg (alloc_dest_reg),
      .alloc_ready    (alloc_ready),
      .alloc_tag      (alloc_tag),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .rd_tag1        (rd_tag1),
      .rd_tag2        (rd_tag2),
      .rd_bsy1        (rd_bsy1),
      .rd_bsy2        (rd_bsy2),
      .rd_val1        (rd_val1),
      .rd_val2        (rd_val2),
      .commit_valid   (commit_valid),
      .commit_reg     (commit_reg),
      .commit_data    (commit_data),
      .commit_tag     (commit_tag),
      .flush          (flush),
      .count          (count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_lookup(input logic [3:0] t, output logic bsy, output logic [31:0] val);
      bsy = 1'b1;
      val = '0;
      foreach (q[i]) begin
         if (q[i].tag == t) begin
            if (cdb_valid && cdb_tag == t) begin
               bsy = 1'b0;
               val = cdb_data;
            end else if (q[i].rdy) begin
               bsy = 1'b0;
               val = q[i].val;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, check every output against the model, then advance.
   task automatic step(input logic av, input logic [4:0] ad,
                       input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                       input logic [3:0] t1, input logic [3:0] t2,
                       input logic fl, input logic rs);
      logic        eb;
      logic [31:0] ev;
      bit          a_fire, c_fire;
      alloc_valid = av; alloc_dest_reg = ad;
      cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
      rd_tag1 = t1; rd_tag2 = t2; flush = fl; rst = rs;
      #2;
      check("count", 32'(count), 32'(q.size()));
      check("alloc_ready", 32'(alloc_ready), 32'(q.size() < 16));
      check("alloc_tag", 32'(alloc_tag), m_tail);
      c_fire = (q.size() > 0) && q[0].rdy;
      check("commit_valid", 32'(commit_valid), 32'(c_fire));
      if (c_fire) begin
         check("commit_reg", 32'(commit_reg), 32'(q[0].dest));
         check("commit_data", commit_data, q[0].val);
         check("commit_tag", 32'(commit_tag), 32'(q[0].tag));
      end
      model_lookup(t1, eb, ev);
      check("rd_bsy1", 32'(rd_bsy1), 32'(eb));
      check("rd_val1", rd_val1, ev);
      model_lookup(t2, eb, ev);
      check("rd_bsy2", 32'(rd_bsy2), 32'(eb));
      check("rd_val2", rd_val2, ev);

      if (rs || fl) begin
         q.delete();
         m_tail = 0;
      end else begin
         a_fire = av && (q.size() < 16);
         if (cv) begin
            foreach (q[i]) begin
               if (q[i].tag == ct) begin
                  q[i].rdy = 1'b1;
                  q[i].val = cd;
               end
            end
         end
         if (c_fire) void'(q.pop_front());
         if (a_fire) begin
            q.push_back('{tag: 4'(m_tail), dest: ad, rdy: 1'b0, val: 32'h0});
            m_tail = (m_tail + 1) % 16;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [3:0] t1, input logic [3:0] t2);
      step(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, t1, t2, 1'b0, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0);
   endtask

   initial begin
      alloc_valid = 0; alloc_dest_reg = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
      rd_tag1 = 0; rd_tag2 = 0; flush = 0; rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;

      // Reset state, then fill to 16 and try a 17th allocation.
      idle(4'd0, 4'd5);
      for (int i = 0; i < 17; i++)
         step(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'h0, 4'(i), 4'd15, 1'b0, 1'b0);
      idle(4'd0, 4'd15);
      do_flush();

      // Out-of-order completion, in-order retirement.
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'(i + 3), 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b1, 4'd2, 32'hCC, 4'd2, 4'd0, 1'b0, 1'b0);
      idle(4'd2, 4'd0);
      step(1'b0, 5'd0, 1'b1, 4'd0, 32'hAA, 4'd0, 4'd2, 1'b0, 1'b0);
      idle(4'd0, 4'd1);
      idle(4'd1, 4'd2);
      step(1'b0, 5'd0, 1'b1, 4'd1, 32'hBB, 4'd1, 4'd2, 1'b0, 1'b0);
      idle(4'd1, 4'd2);
      idle(4'd2, 4'd0);
      do_flush();

      // Same-cycle CDB bypass on a lookup, then the stored value.
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'd7, 1'b0, 4'd0, 32'h0, 4'd3, 4'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b1, 4'd3, 32'h1234, 4'd3, 4'd3, 1'b0, 1'b0);
      idle(4'd3, 4'd2);
      do_flush();

      // Full buffer with a ready head: commit fires, alloc stalls one cycle, then wraps.
      for (int i = 0; i < 16; i++)
         step(1'b1, 5'(i), 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b1, 4'd0, 32'h5A5A, 4'd0, 4'd1, 1'b0, 1'b0);
      step(1'b1, 5'd9, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 1'b0, 1'b0);
      step(1'b1, 5'd9, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 1'b0, 1'b0);
      idle(4'd0, 4'd15);
      do_flush();

      // Flush beats simultaneous alloc and CDB with 7 entries live.
      for (int i = 0; i < 7; i++)
         step(1'b1, 5'(i), 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b1, 4'd0, 32'h77, 4'd0, 4'd1, 1'b0, 1'b0);
      step(1'b1, 5'd3, 1'b1, 4'd1, 32'h99, 4'd1, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         idle(4'(i), 4'(i + 8));

      // Mid-run reset.
      for (int i = 0; i < 5; i++)
         step(1'b1, 5'(i), 1'b1, 4'd0, 32'h11, 4'd0, 4'd1, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 1'b0, 1'b1);
      idle(4'd0, 4'd1);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         logic       av, cv, fl, rs;
         logic [3:0] ct, t1, t2;
         av = ($urandom_range(0, 3) != 0);
         cv = ($urandom_range(0, 9) < 6);
         ct = 4'($urandom_range(0, 15));
         if (q.size() > 0 && $urandom_range(0, 4) != 0)
            ct = q[$urandom_range(0, q.size() - 1)].tag;
         t1 = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[$urandom_range(0, q.size() - 1)].tag
                                                       : 4'($urandom_range(0, 15));
         t2 = ($urandom_range(0, 2) == 0) ? ct : 4'($urandom_range(0, 15));
         fl = ($urandom_range(0, 99) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(av, 5'($urandom), cv, ct, $urandom, t1, t2, fl, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
